// File: rtl/priority_arbiter.sv
// priority_arbiter -- 8-requester arbiter with one registered, one-hot grant.
// A grant is held until the grantee signals done, drops its request, or the
// hold counter expires after HOLD_MAX cycles. There is always one dead cycle
// between grants. A grant revoked by expiry alone is flagged by a one-cycle
// timeout pulse.
// Optional macro ROUND_ROBIN_EN: round-robin selection from a rotating
// pointer. When it is undefined, the highest requesting index wins.
module priority_arbiter #(
  parameter int unsigned HOLD_MAX = 15   // legal range 1..15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] grant,
  output logic [2:0] grant_id,
  output logic       grant_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Value of hold_cnt during the final permitted grant cycle.
  localparam logic [3:0] HOLD_LAST = 4'(HOLD_MAX - 1);

  state_t     r_state;
  logic [7:0] r_grant;
  logic [2:0] r_grant_id;
  logic [3:0] r_hold_cnt;
  logic       r_timeout;

  state_t     w_state_nxt;
  logic [7:0] w_grant_nxt;
  logic [2:0] w_grant_id_nxt;
  logic [3:0] w_hold_cnt_nxt;
  logic       w_timeout_nxt;

  logic [2:0] w_win_id;
  logic       w_expired;
  logic       w_normal_rel;

`ifdef ROUND_ROBIN_EN
  logic [2:0] r_ptr;
  logic [2:0] w_ptr_nxt;
  logic [2:0] w_cand;
  logic       w_found;

  // Search upward from the pointer, wrapping 7 -> 0; the first set bit wins.
  always_comb begin
    w_win_id = '0;
    w_cand   = '0;
    w_found  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      w_cand = r_ptr + 3'(k);
      if (!w_found && req[w_cand]) begin
        w_win_id = w_cand;
        w_found  = 1'b1;
      end
    end
  end

  // Rotating pointer register; it moves only when a grant is issued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= '0;
    else        r_ptr <= w_ptr_nxt;
  end
`else
  // Fixed priority: a later (higher) set index overrides an earlier one.
  always_comb begin
    w_win_id = '0;
    for (int i = 0; i < 8; i++) begin
      if (req[i]) w_win_id = 3'(i);
    end
  end
`endif

  // Release causes. The grantee's own request bit is indexed through the
  // registered grant_id. Other request bits have no effect.
  assign w_normal_rel = done | ~req[r_grant_id];
  assign w_expired    = (r_hold_cnt == HOLD_LAST);

  // Compute the next state and the next registered outputs.
  always_comb begin
    // NOTE: every variable gets a default before the case statement, so no
    // path through the case can leave a value unassigned and infer a latch.
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_hold_cnt_nxt = r_hold_cnt;
    w_timeout_nxt  = 1'b0;
`ifdef ROUND_ROBIN_EN
    w_ptr_nxt      = r_ptr;
`endif
    unique case (r_state)
      IDLE: begin
        // done is ignored here; only a nonzero req starts a grant.
        if (|req) begin
          w_state_nxt    = BUSY;
          w_grant_nxt    = 8'(1) << w_win_id;
          w_grant_id_nxt = w_win_id;
          w_hold_cnt_nxt = '0;
`ifdef ROUND_ROBIN_EN
          w_ptr_nxt      = w_win_id + 3'd1;
`endif
        end
      end
      BUSY: begin
        if (w_normal_rel || w_expired) begin
          w_state_nxt    = IDLE;
          w_grant_nxt    = '0;
          w_grant_id_nxt = '0;
          w_hold_cnt_nxt = '0;
          // A coincident normal release takes precedence over expiry.
          w_timeout_nxt  = w_expired & ~w_normal_rel;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 4'd1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State and output registers. Reset clears them at once, without a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments here make every register sample the
      // values from before the edge, whatever the order of the statements.
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
    end
  end

  assign grant       = r_grant;
  assign grant_id    = r_grant_id;
  assign grant_valid = |r_grant;
  assign timeout     = r_timeout;

endmodule

// File: tb/tb_priority_arbiter.sv
// tb_priority_arbiter -- directed, scoreboard-checked bench for
// priority_arbiter, built with HOLD_MAX=4. The driver applies inputs on the
// falling edge and queues the outputs expected after the next rising edge.
// The monitor dequeues and compares 1 ns after each rising edge.
// The ROUND_ROBIN_EN selection picks the policy-specific sequence.
module tb_priority_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       done;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       timeout;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] id;
    logic       timeout;
    string      name;
  } exp_t;

  exp_t  sb[$];
  string phase = "reset";
  int    n_tests = 0;
  int    n_fail  = 0;

  priority_arbiter #(.HOLD_MAX(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs and queue the outputs expected after the edge.
  task automatic cyc(input logic rn, input logic [7:0] r, input logic d,
                     input logic [7:0] eg, input logic [2:0] eid, input logic et);
    exp_t e;
    @(negedge clk);
    rst_n = rn;
    req   = r;
    done  = d;
    e.grant = eg; e.id = eid; e.timeout = et; e.name = phase;
    sb.push_back(e);
  endtask

  // Monitor: compare {grant, grant_id, grant_valid, timeout} once per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check(e.name, 16'({grant, grant_id, grant_valid, timeout}),
              16'({e.grant, e.id, |e.grant, e.timeout}));
      end
    end
  end

  initial begin
    exp_t z;
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", 16'({grant, grant_id, grant_valid, timeout}), 16'h0);

    // IDLE with no request stays idle, and done alone does nothing.
    phase = "idle";
    cyc(1, 8'h00, 0, 8'h00, 0, 0);
    cyc(1, 8'h00, 1, 8'h00, 0, 0);

    // The grant expires after 4 cycles, then one timeout cycle, then a regrant.
    phase = "expiry";
    repeat (4) cyc(1, 8'h10, 0, 8'h10, 4, 0);
    cyc(1, 8'h10, 0, 8'h00, 0, 1);
    cyc(1, 8'h10, 0, 8'h10, 4, 0);
    cyc(1, 8'h10, 1, 8'h00, 0, 0);
    cyc(1, 8'h00, 0, 8'h00, 0, 0);

    // done in the 4th grant cycle coincides with expiry, so timeout stays 0.
    phase = "done_at_expiry";
    repeat (4) cyc(1, 8'h10, 0, 8'h10, 4, 0);
    cyc(1, 8'h10, 1, 8'h00, 0, 0);
    cyc(1, 8'h00, 0, 8'h00, 0, 0);

    // req[5] drops while req[6] rises: release, dead cycle, then grant 6.
    phase = "handover";
    cyc(1, 8'h20, 0, 8'h20, 5, 0);
    cyc(1, 8'h20, 0, 8'h20, 5, 0);
    cyc(1, 8'h40, 0, 8'h00, 0, 0);
    cyc(1, 8'h40, 0, 8'h40, 6, 0);
    cyc(1, 8'h00, 1, 8'h00, 0, 0);

    // The grant stays stable while other request bits change.
    phase = "stable";
    cyc(1, 8'h04, 0, 8'h04, 2, 0);
    cyc(1, 8'h8C, 0, 8'h04, 2, 0);
    cyc(1, 8'h7C, 0, 8'h04, 2, 0);

    // Asynchronous reset between clock edges during the grant.
    phase = "async_reset";
    @(negedge clk);
    z.grant = '0; z.id = '0; z.timeout = 1'b0; z.name = phase;
    sb.push_back(z);
    #2 rst_n = 1'b0;
    #1 check("reset_immediate", 16'({grant, grant_id, grant_valid, timeout}), 16'h0);
    cyc(0, 8'h04, 0, 8'h00, 0, 0);
    phase = "after_reset";
    cyc(1, 8'h04, 0, 8'h04, 2, 0);
    cyc(1, 8'h00, 0, 8'h00, 0, 0);

`ifdef ROUND_ROBIN_EN
    // Round robin from a pointer reset to 0: 0,1,...,7,0 with dead cycles.
    phase = "rr_reset";
    cyc(0, 8'h00, 0, 8'h00, 0, 0);
    phase = "round_robin";
    for (int k = 0; k < 9; k++) begin
      cyc(1, 8'hFF, 0, 8'(1) << (k % 8), 3'(k % 8), 0);
      cyc(1, 8'hFF, 1, 8'h00, 0, 0);
    end
    cyc(1, 8'h00, 0, 8'h00, 0, 0);
`else
    // Fixed priority: requester 7 always beats requester 0.
    phase = "fixed_priority";
    for (int k = 0; k < 3; k++) begin
      cyc(1, 8'h81, (k != 0), 8'h80, 7, 0);
      cyc(1, 8'h81, 1, 8'h00, 0, 0);
    end
    phase = "fixed_all";
    cyc(1, 8'hFF, 0, 8'h80, 7, 0);
    cyc(1, 8'hFF, 1, 8'h00, 0, 0);
    cyc(1, 8'h00, 0, 8'h00, 0, 0);
`endif

    repeat (2) @(negedge clk);
    check("scoreboard_drained", 16'(sb.size()), 16'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/priority_arbiter.md
PRIORITY_ARBITER -- requirements
Module: priority_arbiter

Interface
REQ-001 Parameter HOLD_MAX, default 15, maximum number of consecutive cycles one grant is held; legal range is 1 to 15.
REQ-002 Port clk, input, 1 bit, single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 Port req, input, 8 bits, request per requester; index 0..7.
REQ-005 Port done, input, 1 bit, the current grantee finishes its transfer this cycle.
REQ-006 Port grant, output, 8 bits, one-hot grant, registered.
REQ-007 Port grant_id, output, 3 bits, binary index of the granted requester, registered.
REQ-008 Port grant_valid, output, 1 bit, high while any grant is held; equals the OR of grant.
REQ-009 Port timeout, output, 1 bit, one-cycle pulse marking a grant revoked by HOLD_MAX expiry.

Function
REQ-010 The FSM SHALL have exactly two states: IDLE (no grant) and BUSY (grant held).
REQ-011 In IDLE with req nonzero at a clock edge, the block SHALL enter BUSY and drive grant, grant_id and grant_valid from the next cycle (1-cycle latency).
REQ-012 In IDLE with req equal to 0, the block SHALL remain in IDLE with all outputs 0.
REQ-013 Winner selection SHALL be a priority encode: fixed-priority mode grants the highest set index.
REQ-014 The grant_id and grant outputs SHALL remain stable for the whole of BUSY, independent of changes on non-granted req bits.
REQ-015 hold_cnt is a 4-bit counter; it SHALL be cleared on grant issue and SHALL increment on each BUSY cycle.
REQ-016 Release condition: sampled in BUSY, done=1, or req[grant_id]=0, or hold_cnt==HOLD_MAX-1.
REQ-017 On release the block SHALL return to IDLE, and grant, grant_id and grant_valid SHALL be 0 in the following cycle.
REQ-018 There SHALL be one mandatory dead cycle between consecutive grants, even with requests pending.
REQ-019 A grant SHALL be held at most HOLD_MAX cycles.
REQ-020 timeout SHALL pulse for exactly one cycle, coincident with the first deasserted-grant cycle, only when expiry is the sole release cause.
REQ-021 If done or req[grant_id]=0 coincides with expiry, the release SHALL be treated as normal and timeout SHALL stay 0.
REQ-022 done SHALL be ignored while in IDLE.
REQ-023 grant SHALL never have more than one bit set.

Reset
REQ-024 rst_n=0 SHALL immediately, without a clock, force IDLE, grant=0, grant_id=0, grant_valid=0, timeout=0, hold_cnt=0 and the round-robin pointer to 0.
REQ-025 A reset asserted mid-grant SHALL drop the grant immediately, with no timeout pulse.
REQ-026 After rst_n deasserts, the first grant SHALL follow the REQ-011 timing.

Configuration
REQ-027 Macro ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-028 With ROUND_ROBIN_EN defined, the block SHALL hold a 3-bit pointer set to grant_id+1 (mod 8) on each grant issue.
REQ-029 With ROUND_ROBIN_EN defined, selection SHALL search upward from the pointer, wrapping 7 to 0, and grant the first set bit.
REQ-030 With ROUND_ROBIN_EN undefined, the block SHALL use fixed priority (REQ-013), SHALL have no pointer logic, and all other behaviour SHALL be identical.

Verification
REQ-031 Fixed priority, req=8'b1000_0001 held, done pulsed each BUSY cycle -> grant_id=7 on every grant; requester 0 is never granted.
REQ-032 ROUND_ROBIN_EN, req=8'hFF held, done pulsed on each grant's first cycle -> grant_id sequence 0,1,2,...,7,0 with one dead cycle between grants.
REQ-033 HOLD_MAX=4, req=8'h10 held, done=0 -> grant=8'h10 for exactly 4 cycles, then grant=0 with timeout=1 for one cycle, then grant_id=4 again after the dead cycle.
REQ-034 HOLD_MAX=4, done=1 in the 4th grant cycle -> grant released with timeout=0.
REQ-035 Grant to index 2 active, rst_n pulled low between edges -> grant, grant_valid and timeout are 0 immediately; after release, req=8'h04 -> grant_id=2 one cycle later.
REQ-036 Grant to index 5 active, req[5] drops while req[6] rises -> grant=0 next cycle, then grant_id=6 one cycle after that.
